// File: rtl/bram_stream_reader.sv
// Streams a contiguous, wrapping BRAM address range out on a valid/ready port.
// The BRAM's one-cycle read latency is hidden by a 2-entry output FIFO with credit-based issue.
module bram_stream_reader #(
   parameter int BRAM_ADDR_WIDTH = 10,
   parameter int BRAM_DATA_WIDTH = 8
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       start,
   input  logic [BRAM_ADDR_WIDTH-1:0] base_addr,
   input  logic [BRAM_ADDR_WIDTH:0]   length,
   output logic                       busy,
   output logic                       done,
   output logic [BRAM_ADDR_WIDTH-1:0] rd_addr,
   input  logic [BRAM_DATA_WIDTH-1:0] rd_data,
   output logic [BRAM_DATA_WIDTH-1:0] out_data,
   output logic                       out_valid,
   input  logic                       out_ready
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_ONE = 1;
   localparam logic [BRAM_ADDR_WIDTH:0]   REM_ONE  = 1;
   localparam logic [BRAM_ADDR_WIDTH:0]   REM_ZERO = 0;

   logic [1:0]                 state;
   logic [BRAM_ADDR_WIDTH-1:0] addr_reg;
   logic [BRAM_ADDR_WIDTH:0]   remaining;
   logic                       pending;
   logic                       tail_valid;
   logic [BRAM_DATA_WIDTH-1:0] tail_data;

   logic       pop;
   logic       push;
   logic       issue;
   logic       last_pop;
   logic [1:0] occupancy;
   logic [1:0] credit;

   assign pop       = out_valid & out_ready;
   assign push      = pending;
   assign busy      = (state != IDLE);
   assign rd_addr   = addr_reg;

   // Words already buffered or in flight must leave room for the read issued now.
   assign occupancy = {1'b0, out_valid} + {1'b0, tail_valid} + {1'b0, pending};
   assign credit    = 2'd1 + {1'b0, pop};
   assign issue     = (state == READ) && (occupancy <= credit);
   assign last_pop  = (state == DRAIN) && pop && !tail_valid && !pending;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         addr_reg  <= '0;
         remaining <= '0;
         pending   <= 1'b0;
         done      <= 1'b0;
      end else begin
         done    <= 1'b0;
         pending <= issue;
         case (state)
            IDLE: begin
               if (start) begin
                  addr_reg  <= base_addr;
                  remaining <= length;
                  if (length == REM_ZERO) done  <= 1'b1;
                  else                    state <= READ;
               end
            end
            READ: begin
               if (issue) begin
                  addr_reg  <= addr_reg + ADDR_ONE;
                  remaining <= remaining - REM_ONE;
                  if (remaining == REM_ONE) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (last_pop) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Head register doubles as the registered output; tail absorbs one word of backpressure.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         tail_valid <= 1'b0;
         tail_data  <= '0;
      end else begin
         case ({out_valid, tail_valid})
            2'b00: begin
               if (push) begin
                  out_valid <= 1'b1;
                  out_data  <= rd_data;
               end
            end
            2'b10: begin
               if (pop && push) begin
                  out_data <= rd_data;
               end else if (pop) begin
                  out_valid <= 1'b0;
               end else if (push) begin
                  tail_valid <= 1'b1;
                  tail_data  <= rd_data;
               end
            end
            2'b11: begin
               if (pop) begin
                  out_data <= tail_data;
                  if (push) tail_data  <= rd_data;
                  else      tail_valid <= 1'b0;
               end
            end
            default: begin
               tail_valid <= 1'b0;
            end
         endcase
      end
   end

   fifo_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
      !(push && !pop && out_valid && tail_valid));

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: behavioural BRAM plus an address-order word model,
// with randomized backpressure and per-scenario inline comparisons.
module tb_bram_stream_reader;

   localparam int AW    = 10;
   localparam int DW    = 8;
   localparam int DEPTH = 1 << AW;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   length = '0;
   logic          busy;
   logic          done;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;

   logic [DW-1:0] mem [DEPTH];

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] got_q [$];
   int            first_cyc, last_cyc, done_cyc, hold_err, busy_err, overlap_err;
   bit            timed_out;
   logic [AW-1:0] addr_trace [16];

   bram_stream_reader #(.BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .busy      (busy),
      .done      (done),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clock = ~clock;

   // BRAM with registered read address
   always @(posedge clock) rd_data <= mem[rd_addr];

   function automatic logic [DW-1:0] ref_word(input int b, input int k);
      return mem[AW'((b + k) % DEPTH)];
   endfunction

   task automatic fill_mem(input bit ramp);
      for (int i = 0; i < DEPTH; i++) mem[i] = ramp ? DW'(i) : DW'($urandom);
   endtask

   // Caller must be at a falling edge; returns at the falling edge of the done cycle.
   // mode 0: ready high; 1: 1,0,0,1 pattern then random; 2: ready low in cycles 3..12.
   task automatic do_transfer(input int b, input int n, input int mode, input int restart_cyc);
      int            cyc;
      int            limit;
      logic          rdy;
      logic          prev_stall;
      logic [DW-1:0] prev_data;
      got_q.delete();
      first_cyc = -1; last_cyc = -1; done_cyc = -1;
      hold_err = 0; busy_err = 0; overlap_err = 0; timed_out = 1'b0;
      limit = 4 * n + 60;
      start = 1'b1; base_addr = AW'(b); length = (AW+1)'(n); out_ready = 1'b1;
      cyc = 0; prev_stall = 1'b0; prev_data = '0;
      forever begin
         @(negedge clock);
         cyc++;
         start = (cyc == restart_cyc);
         if (start) begin
            base_addr = AW'(b + 100);
            length    = (AW+1)'(3);
         end
         if (cyc < 16) addr_trace[cyc] = rd_addr;
         if (prev_stall && out_data !== prev_data) hold_err++;
         if (done === 1'b1) begin
            done_cyc = cyc;
            if (out_valid !== 1'b0 || busy !== 1'b0) overlap_err++;
            break;
         end
         if (n != 0 && busy !== 1'b1) busy_err++;
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc <= 12) ? (((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3))
                                       : 1'($urandom_range(0, 1));
            default: rdy = !(cyc >= 3 && cyc <= 12);
         endcase
         out_ready = rdy;
         if (out_valid === 1'b1 && rdy) begin
            got_q.push_back(out_data);
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
         end
         prev_stall = (out_valid === 1'b1) && !rdy;
         prev_data  = out_data;
         if (cyc >= limit) begin
            timed_out = 1'b1;
            break;
         end
      end
      start = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, required 0", done); end
      n_checks++; if (rd_addr !== '0) begin n_fail++; $display("FAIL reset_rd_addr: got %0d, required 0", rd_addr); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
      n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %0h, required 0", out_data); end
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_basic;
      int mism;
      fill_mem(1'b1);
      do_transfer(5, 4, 0, 0);
      mism = 0;
      for (int k = 0; k < 4; k++) if (k >= got_q.size() || got_q[k] !== ref_word(5, k)) mism++;
      n_checks++; if (timed_out) begin n_fail++; $display("FAIL basic_timeout: transfer did not finish, required done"); end
      n_checks++; if (got_q.size() != 4 || mism != 0) begin n_fail++; $display("FAIL basic_data: got %0d words %0d wrong, required 4 words 0 wrong", got_q.size(), mism); end
      n_checks++; if (first_cyc != 3) begin n_fail++; $display("FAIL basic_first_cycle: got %0d, required 3", first_cyc); end
      n_checks++; if (last_cyc != 6) begin n_fail++; $display("FAIL basic_last_cycle: got %0d, required 6", last_cyc); end
      n_checks++; if (done_cyc != 7) begin n_fail++; $display("FAIL basic_done_cycle: got %0d, required 7", done_cyc); end
      n_checks++; if (busy_err != 0 || overlap_err != 0) begin n_fail++; $display("FAIL basic_busy: got %0d busy-low cycles %0d overlap, required 0 0", busy_err, overlap_err); end
      n_checks++; if (addr_trace[1] !== AW'(5)) begin n_fail++; $display("FAIL basic_rd_addr_c1: got %0d, required 5", addr_trace[1]); end
      @(negedge clock);
      n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got done=%b busy=%b, required 0 0", done, busy); end
   endtask

   task automatic test_backpressure;
      int mism;
      int b;
      int n;
      fill_mem(1'b0);
      do_transfer(0, 8, 1, 0);
      mism = 0;
      for (int k = 0; k < 8; k++) if (k >= got_q.size() || got_q[k] !== ref_word(0, k)) mism++;
      n_checks++; if (timed_out || got_q.size() != 8 || mism != 0) begin n_fail++; $display("FAIL bp_data: got %0d words %0d wrong timeout=%0d, required 8 words 0 wrong", got_q.size(), mism, timed_out); end
      n_checks++; if (hold_err != 0) begin n_fail++; $display("FAIL bp_hold: got %0d changes while stalled, required 0", hold_err); end
      for (int r = 0; r < 3; r++) begin
         b = $urandom_range(0, DEPTH - 1);
         n = $urandom_range(1, 40);
         do_transfer(b, n, 1, 0);
         mism = 0;
         for (int k = 0; k < n; k++) if (k >= got_q.size() || got_q[k] !== ref_word(b, k)) mism++;
         n_checks++; if (timed_out || got_q.size() != n || mism != 0 || hold_err != 0 || overlap_err != 0) begin
            n_fail++;
            $display("FAIL bp_random_%0d: got %0d words %0d wrong hold_err=%0d overlap=%0d, required %0d words 0 0 0", r, got_q.size(), mism, hold_err, overlap_err, n);
         end
      end
      b = $urandom_range(0, DEPTH - 1);
      do_transfer(b, 8, 2, 0);
      mism = 0;
      for (int k = 0; k < 8; k++) if (k >= got_q.size() || got_q[k] !== ref_word(b, k)) mism++;
      n_checks++; if (addr_trace[12] !== AW'((b + 2) % DEPTH)) begin n_fail++; $display("FAIL bp_stall_addr: got %0d, required %0d", addr_trace[12], (b + 2) % DEPTH); end
      n_checks++; if (timed_out || got_q.size() != 8 || mism != 0 || hold_err != 0) begin n_fail++; $display("FAIL bp_stall_data: got %0d words %0d wrong hold_err=%0d, required 8 0 0", got_q.size(), mism, hold_err); end
      n_checks++; if (last_cyc - first_cyc != 7) begin n_fail++; $display("FAIL bp_resume_rate: got span %0d, required 7", last_cyc - first_cyc); end
   endtask

   task automatic test_wrap;
      int mism;
      int amism;
      do_transfer(1022, 4, 0, 0);
      mism = 0; amism = 0;
      for (int k = 0; k < 4; k++) begin
         if (k >= got_q.size() || got_q[k] !== ref_word(1022, k)) mism++;
         if (addr_trace[k + 1] !== AW'((1022 + k) % DEPTH)) amism++;
      end
      n_checks++; if (amism != 0) begin n_fail++; $display("FAIL wrap_addr: got %0d,%0d,%0d,%0d, required 1022,1023,0,1", addr_trace[1], addr_trace[2], addr_trace[3], addr_trace[4]); end
      n_checks++; if (timed_out || got_q.size() != 4 || mism != 0) begin n_fail++; $display("FAIL wrap_data: got %0d words %0d wrong, required 4 words 0 wrong", got_q.size(), mism); end
   endtask

   task automatic test_len_zero_and_restart;
      int mism;
      int b;
      int stray;
      do_transfer($urandom_range(0, DEPTH - 1), 0, 0, 0);
      n_checks++; if (done_cyc != 1 || got_q.size() != 0 || overlap_err != 0) begin n_fail++; $display("FAIL len0: got done cycle %0d words %0d overlap %0d, required 1 0 0", done_cyc, got_q.size(), overlap_err); end
      b = $urandom_range(0, DEPTH - 1);
      do_transfer(b, 6, 0, 3);
      mism = 0;
      for (int k = 0; k < 6; k++) if (k >= got_q.size() || got_q[k] !== ref_word(b, k)) mism++;
      n_checks++; if (got_q.size() != 6 || mism != 0) begin n_fail++; $display("FAIL restart_data: got %0d words %0d wrong, required 6 words 0 wrong", got_q.size(), mism); end
      n_checks++; if (done_cyc != 9) begin n_fail++; $display("FAIL restart_done_cycle: got %0d, required 9", done_cyc); end
      stray = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) stray++;
      end
      n_checks++; if (stray != 0) begin n_fail++; $display("FAIL restart_ignored: got %0d active cycles after done, required 0", stray); end
   endtask

   task automatic test_reset_mid;
      int   b;
      int   mism;
      logic valid_before;
      b = $urandom_range(0, DEPTH - 1);
      start = 1'b1; base_addr = AW'(b); length = (AW+1)'(16); out_ready = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clock);
         start = 1'b0;
      end
      valid_before = out_valid;
      reset_n = 1'b0;
      #1;
      n_checks++; if (valid_before !== 1'b1) begin n_fail++; $display("FAIL rstmid_prior_valid: got %b, required 1", valid_before); end
      n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rstmid_async: got valid=%b busy=%b done=%b, required 0 0 0", out_valid, busy, done); end
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rstmid_after: got valid=%b busy=%b done=%b, required 0 0 0", out_valid, busy, done); end
      do_transfer(0, 2, 0, 0);
      mism = 0;
      for (int k = 0; k < 2; k++) if (k >= got_q.size() || got_q[k] !== ref_word(0, k)) mism++;
      n_checks++; if (timed_out || got_q.size() != 2 || mism != 0 || first_cyc != 3 || done_cyc != 5) begin
         n_fail++;
         $display("FAIL rstmid_fresh: got %0d words %0d wrong first=%0d done=%0d, required 2 0 3 5", got_q.size(), mism, first_cyc, done_cyc);
      end
   endtask

   task automatic test_back_to_back;
      int b1;
      int b2;
      int mism;
      b1 = $urandom_range(0, DEPTH - 1);
      b2 = $urandom_range(0, DEPTH - 1);
      do_transfer(b1, 5, 1, 0);
      mism = 0;
      for (int k = 0; k < 5; k++) if (k >= got_q.size() || got_q[k] !== ref_word(b1, k)) mism++;
      n_checks++; if (timed_out || got_q.size() != 5 || mism != 0) begin n_fail++; $display("FAIL b2b_first: got %0d words %0d wrong, required 5 0", got_q.size(), mism); end
      do_transfer(b2, 3, 0, 0);
      mism = 0;
      for (int k = 0; k < 3; k++) if (k >= got_q.size() || got_q[k] !== ref_word(b2, k)) mism++;
      n_checks++; if (got_q.size() != 3 || mism != 0 || first_cyc != 3 || done_cyc != 6) begin
         n_fail++;
         $display("FAIL b2b_second: got %0d words %0d wrong first=%0d done=%0d, required 3 0 3 6", got_q.size(), mism, first_cyc, done_cyc);
      end
   endtask

   task automatic test_full_depth;
      int b;
      int mism;
      b = $urandom_range(0, DEPTH - 1);
      do_transfer(b, DEPTH, 0, 0);
      mism = 0;
      for (int k = 0; k < DEPTH; k++) if (k >= got_q.size() || got_q[k] !== ref_word(b, k)) mism++;
      n_checks++; if (timed_out || got_q.size() != DEPTH || mism != 0) begin n_fail++; $display("FAIL full_data: got %0d words %0d wrong, required %0d 0", got_q.size(), mism, DEPTH); end
      n_checks++; if (first_cyc != 3 || last_cyc != DEPTH + 2) begin n_fail++; $display("FAIL full_rate: got first=%0d last=%0d, required 3 %0d", first_cyc, last_cyc, DEPTH + 2); end
      n_checks++; if (done_cyc != DEPTH + 3) begin n_fail++; $display("FAIL full_done_cycle: got %0d, required %0d", done_cyc, DEPTH + 3); end
   endtask

   initial begin
      fill_mem(1'b1);
      @(negedge clock);
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_len_zero_and_restart();
      test_reset_mid();
      test_back_to_back();
      test_full_depth();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
